// File: rtl/inv_sqrt_arbiter.sv
// Round-robin arbiter sharing one non-pipelined fastInvSqrt core between NUM_REQ requesters.
// One operation in flight; zero operands are answered locally, and a hung core is aborted
// after TIMEOUT cycles.
module inv_sqrt_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned INT_WIDTH   = 12,
   parameter int unsigned FRACT_WIDTH = 4,
   parameter int unsigned TIMEOUT     = 64,
   localparam int unsigned W          = INT_WIDTH + FRACT_WIDTH,
   localparam int unsigned IW         = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*W-1:0] req_data,
   output logic [NUM_REQ-1:0]   rsp_valid,
   input  logic [NUM_REQ-1:0]   rsp_ready,
   output logic [W-1:0]         rsp_data,
   output logic                 rsp_err,
   output logic [W-1:0]         core_data_in,
   output logic                 core_valid_in,
   input  logic                 core_ready_in,
   input  logic [W-1:0]         core_data_out,
   input  logic                 core_valid_out,
   output logic                 core_ready_out,
   output logic                 busy,
   output logic [IW-1:0]        grant_id
);

   // One extra bit so the counter cannot wrap past TIMEOUT-1.
   localparam int unsigned TW = $clog2(TIMEOUT) + 1;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StIssue = 2'd1;
   localparam logic [1:0] StWait  = 2'd2;
   localparam logic [1:0] StResp  = 2'd3;

   logic [1:0]         state_q;
   logic [IW-1:0]      rr_ptr_q;
   logic [IW-1:0]      grant_q;
   logic [W-1:0]       core_data_in_q;
   logic               core_valid_in_q;
   logic               core_ready_out_q;
   logic [NUM_REQ-1:0] rsp_valid_q;
   logic [W-1:0]       rsp_data_q;
   logic               rsp_err_q;
   logic [TW-1:0]      tmo_cnt_q;

   logic               pick_found;
   logic [IW-1:0]      pick_id;
   logic               accept;
   logic [W-1:0]       acc_data;
   logic [NUM_REQ-1:0] grant_onehot;
   logic               tmo_hit;

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         int unsigned idx;
         idx = (32'(rr_ptr_q) + k) % NUM_REQ;
         if (!pick_found && req_valid[IW'(idx)]) begin
            pick_found = 1'b1;
            pick_id    = IW'(idx);
         end
      end
   end

   assign accept       = (state_q == StIdle) && pick_found && !rst;
   assign req_ready    = accept ? (NUM_REQ'(1) << pick_id) : '0;
   assign acc_data     = req_data[32'(pick_id) * W +: W];
   assign grant_onehot = NUM_REQ'(1) << grant_q;
   assign tmo_hit      = (tmo_cnt_q >= TW'(TIMEOUT - 1));

   // Control FSM: accept, issue to core, wait for result or timeout, hold response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= StIdle;
         rr_ptr_q         <= IW'(NUM_REQ - 1);
         grant_q          <= '0;
         core_data_in_q   <= '0;
         core_valid_in_q  <= 1'b0;
         core_ready_out_q <= 1'b0;
         rsp_valid_q      <= '0;
         rsp_data_q       <= '0;
         rsp_err_q        <= 1'b0;
         tmo_cnt_q        <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  rr_ptr_q <= pick_id;
                  grant_q  <= pick_id;
                  if (acc_data == '0) begin
                     // 1/sqrt(0) is undefined: answer locally without touching the core.
                     rsp_data_q  <= '1;
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= req_ready;
                     state_q     <= StResp;
                  end else begin
                     core_data_in_q  <= acc_data;
                     core_valid_in_q <= 1'b1;
                     tmo_cnt_q       <= '0;
                     state_q         <= StIssue;
                  end
               end
            end
            StIssue: begin
               if (core_valid_in_q && core_ready_in) begin
                  core_valid_in_q  <= 1'b0;
                  core_ready_out_q <= 1'b1;
                  tmo_cnt_q        <= tmo_cnt_q + 1'b1;
                  state_q          <= StWait;
               end else if (tmo_hit) begin
                  core_valid_in_q  <= 1'b0;
                  core_ready_out_q <= 1'b0;
                  rsp_data_q       <= '1;
                  rsp_err_q        <= 1'b1;
                  rsp_valid_q      <= grant_onehot;
                  state_q          <= StResp;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            StWait: begin
               // Completion is checked first so it wins over a simultaneous timeout.
               if (core_valid_out) begin
                  core_ready_out_q <= 1'b0;
                  rsp_data_q       <= core_data_out;
                  rsp_err_q        <= 1'b0;
                  rsp_valid_q      <= grant_onehot;
                  state_q          <= StResp;
               end else if (tmo_hit) begin
                  core_ready_out_q <= 1'b0;
                  rsp_data_q       <= '1;
                  rsp_err_q        <= 1'b1;
                  rsp_valid_q      <= grant_onehot;
                  state_q          <= StResp;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            StResp: begin
               if (rsp_ready[grant_q]) begin
                  rsp_valid_q <= '0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign core_data_in   = core_data_in_q;
   assign core_valid_in  = core_valid_in_q;
   assign core_ready_out = core_ready_out_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_data       = rsp_data_q;
   assign rsp_err        = rsp_err_q;
   assign busy           = (state_q != StIdle);
   assign grant_id       = grant_q;

endmodule

// File: tb/tb_inv_sqrt_arbiter.sv
// Bench for inv_sqrt_arbiter: behavioural core stub, directed stimulus, scoreboard monitor.
module tb_inv_sqrt_arbiter;

   localparam int NR = 4;
   localparam int W  = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [NR*W-1:0] req_data;
   logic [NR-1:0]   rsp_valid;
   logic [NR-1:0]   rsp_ready;
   logic [W-1:0]    rsp_data;
   logic            rsp_err;
   logic [W-1:0]    core_data_in;
   logic            core_valid_in;
   logic            core_ready_in;
   logic [W-1:0]    core_data_out;
   logic            core_valid_out;
   logic            core_ready_out;
   logic            busy;
   logic [1:0]      grant_id;

   always #5 clk = ~clk;

   inv_sqrt_arbiter #(
      .NUM_REQ(NR), .INT_WIDTH(12), .FRACT_WIDTH(4), .TIMEOUT(64)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .core_data_in(core_data_in), .core_valid_in(core_valid_in),
      .core_ready_in(core_ready_in), .core_data_out(core_data_out),
      .core_valid_out(core_valid_out), .core_ready_out(core_ready_out),
      .busy(busy), .grant_id(grant_id)
   );

   typedef struct {
      int         id;
      logic [W-1:0] data;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   int   grant_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cvi_cnt = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
      end
   endfunction

   // Core stub: Q12.4 1/sqrt(x), result one cycle after stub_lat countdown; can hang.
   function automatic logic [W-1:0] ref_isqrt(logic [W-1:0] x);
      real r;
      if (x == 0) return '1;
      r = 16.0 / $sqrt(real'(x) / 16.0);
      return W'($rtoi(r + 0.5));
   endfunction

   int           stub_lat  = 0;
   logic         stub_hang = 1'b0;
   logic         st_busy;
   int           st_cnt;
   logic [W-1:0] st_data;

   assign core_ready_in = !st_busy;

   always @(posedge clk) begin
      if (rst) begin
         st_busy        <= 1'b0;
         st_cnt         <= 0;
         st_data        <= '0;
         core_valid_out <= 1'b0;
         core_data_out  <= '0;
      end else begin
         core_valid_out <= 1'b0;
         if (!st_busy && core_valid_in) begin
            st_busy <= 1'b1;
            st_cnt  <= stub_lat;
            st_data <= ref_isqrt(core_data_in);
         end else if (st_busy && stub_hang) begin
            // Aborted by the arbiter: drop the operation.
            if (!core_valid_in && !core_ready_out) st_busy <= 1'b0;
         end else if (st_busy) begin
            if (st_cnt == 0) begin
               core_valid_out <= 1'b1;
               core_data_out  <= st_data;
               st_busy        <= 1'b0;
            end else begin
               st_cnt <= st_cnt - 1;
            end
         end
      end
   end

   always @(negedge clk) if (core_valid_in) cvi_cnt <= cvi_cnt + 1;

   // Scoreboard monitor: compare each accepted response against the queue head.
   always @(negedge clk) begin
      if (!rst && ((rsp_valid & rsp_ready) != 0)) begin
         int   id;
         exp_t e;
         id = -1;
         for (int i = 0; i < NR; i++) if (rsp_valid[i]) id = i;
         check("rsp_onehot", $countones(rsp_valid), 1);
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            check("rsp_id", id, e.id);
            check("rsp_data", rsp_data, e.data);
            check("rsp_err", rsp_err, e.err);
         end
      end
   end

   function automatic void push_exp(int id, logic [W-1:0] d, logic err);
      exp_t e;
      e.id = id; e.data = d; e.err = err;
      exp_q.push_back(e);
   endfunction

   task automatic set_data(int i, logic [W-1:0] d);
      req_data[i*W +: W] = d;
   endtask

   task automatic wait_accept(output int id);
      int c;
      c  = 0;
      id = -1;
      while (id < 0 && c < 300) begin
         @(negedge clk);
         for (int i = 0; i < NR; i++) if (req_ready[i]) id = i;
         c++;
      end
      if (id < 0) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got no grant, want one within 300 cycles");
      end
   endtask

   // Accept n requests, checking grant order; returns just after the last accept edge.
   task automatic do_grants(int n, bit drop_each);
      int id;
      for (int k = 0; k < n; k++) begin
         wait_accept(id);
         if (grant_q.size() > 0) check("grant_order", id, grant_q.pop_front());
         @(posedge clk); #1;
         if (drop_each && id >= 0) req_valid[id] = 1'b0;
      end
      if (!drop_each) req_valid = '0;
   endtask

   // Cycles after the accept cycle until rsp_valid is seen.
   task automatic wait_rsp(output int cyc);
      cyc = 1;
      while (rsp_valid == 0 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic wait_drain();
      int c;
      c = 0;
      while ((exp_q.size() != 0 || busy) && c < 1000) begin
         @(posedge clk); #1;
         c++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   int lat;
   int c0;
   int hold_bad;
   int c;

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = '1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctl", {busy, req_ready, rsp_valid, rsp_err, core_valid_in,
                          core_ready_out, grant_id}, 0);
      check("reset_data", {rsp_data, core_data_in}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // All four requesting: round-robin from requester 0.
      set_data(0, 16'h0040); set_data(1, 16'h0010);
      set_data(2, 16'h0100); set_data(3, 16'h0004);
      foreach (grant_q[i]) grant_q.delete(i);
      grant_q = '{0, 1, 2, 3, 0};
      push_exp(0, 16'h0008, 1'b0); push_exp(1, 16'h0010, 1'b0);
      push_exp(2, 16'h0004, 1'b0); push_exp(3, 16'h0020, 1'b0);
      push_exp(0, 16'h0008, 1'b0);
      req_valid = 4'b1111;
      do_grants(5, 1'b0);
      wait_drain();

      // Single request 4.0 -> 0.5; issue, 2 stub cycles, capture.
      set_data(0, 16'h0040);
      push_exp(0, 16'h0008, 1'b0);
      req_valid = 4'b0001;
      c0 = cvi_cnt;
      do_grants(1, 1'b1);
      wait_rsp(lat);
      check("core_latency", lat, 4);
      wait_drain();
      check("core_used", (cvi_cnt != c0), 1);

      // Zero operand bypass.
      set_data(2, 16'h0000);
      push_exp(2, 16'hFFFF, 1'b1);
      req_valid = 4'b0100;
      c0 = cvi_cnt;
      grant_q.push_back(2);
      do_grants(1, 1'b1);
      check("zero_rsp_valid", rsp_valid, 4'b0100);
      check("zero_rsp_data", rsp_data, 16'hFFFF);
      wait_drain();
      check("zero_no_core", cvi_cnt - c0, 0);

      // Hung core: abort after 64 cycles in issue+wait.
      stub_hang = 1'b1;
      set_data(1, 16'h0010);
      push_exp(1, 16'hFFFF, 1'b1);
      req_valid = 4'b0010;
      do_grants(1, 1'b1);
      wait_rsp(lat);
      check("timeout_latency", lat, 65);
      check("timeout_core_idle", {core_valid_in, core_ready_out}, 0);
      @(posedge clk); #1;
      check("timeout_back_idle", busy, 0);
      stub_hang = 1'b0;
      wait_drain();

      // Response held under back-pressure while others wait.
      set_data(3, 16'h0004);
      set_data(0, 16'h0040); set_data(1, 16'h0010); set_data(2, 16'h0100);
      push_exp(3, 16'h0020, 1'b0); push_exp(0, 16'h0008, 1'b0);
      push_exp(1, 16'h0010, 1'b0); push_exp(2, 16'h0004, 1'b0);
      rsp_ready = 4'b0111;
      req_valid = 4'b1000;
      grant_q.push_back(3);
      do_grants(1, 1'b1);
      req_valid = 4'b0111;
      wait_rsp(lat);
      check("hold_data", rsp_data, 16'h0020);
      hold_bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (rsp_data != 16'h0020 || rsp_err || rsp_valid != 4'b1000 || req_ready != 0 || !busy)
            hold_bad++;
         @(posedge clk); #1;
      end
      check("hold_stable", hold_bad, 0);
      rsp_ready = '1;
      grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(2);
      do_grants(3, 1'b1);
      wait_drain();

      // Reset during wait: everything clears, requester 0 wins next.
      stub_lat = 10;
      set_data(1, 16'h0010);
      req_valid = 4'b0010;
      do_grants(1, 1'b1);
      c = 0;
      while (!core_ready_out && c < 50) begin
         @(posedge clk); #1;
         c++;
      end
      check("reached_wait", core_ready_out, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_ctl", {busy, req_ready, rsp_valid, rsp_err, core_valid_in,
                            core_ready_out, grant_id}, 0);
      check("rst_mid_data", {rsp_data, core_data_in}, 0);
      rst      = 1'b0;
      stub_lat = 0;
      @(posedge clk); #1;
      set_data(0, 16'h0040);
      push_exp(0, 16'h0008, 1'b0);
      grant_q.push_back(0);
      req_valid = 4'b1111;
      do_grants(1, 1'b0);
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
